uart_echo_chip_top: RTL and testbench
=====================================

Name: uart_echo_chip_top

Overview:
- Minimal chip-level top for bring-up.
- A UART receiver on `rxd` echoes every correctly framed byte back on `txd`.
- The last received byte is shown on `led`; sticky error flags are shown on `err`.
- With `SPI_EN` defined, each byte first makes a round trip through an SPI master, and the byte read back on `spi_miso` is the one echoed.

Parameters:
- `CLKS_PER_BIT`, default 1736: UART bit period in `clk_p` cycles (200 MHz / 115200). Minimum 8.
- `SPI_DIV`, default 4: SPI SCLK half-period in `clk_p` cycles. Minimum 1.

Ports:
- `clk_p` input 1: system clock, positive leg. All logic runs on its rising edge.
- `clk_n` input 1: negative leg of the differential clock. Accepted for pin compatibility; unused internally.
- `rst_top` input 1: reset, synchronous, active-low.
- `rxd` input 1: UART receive, idle high, asynchronous to `clk_p`.
- `txd` output 1: UART transmit, idle high.
- `led` output 8: last validly received byte.
- `err` output 2: bit0 = framing error (sticky), bit1 = overrun (sticky).
- `spi_cs` output 1: SPI chip select, active low. Present only with `SPI_EN`.
- `spi_sclk` output 1: SPI clock, mode 0. Present only with `SPI_EN`.
- `spi_mosi` output 1: SPI data out, MSB first. Present only with `SPI_EN`.
- `spi_miso` input 1: SPI data in. Present only with `SPI_EN`.

Behaviour:
- Reset (`rst_top`=0 at a rising `clk_p` edge):
  - `txd`=1, `led`=0, `err`=0, `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0.
  - All FSMs go to IDLE; holding register is emptied; the `rxd` synchronizer is preset to 1.
  - Reset asserted mid-frame aborts the frame; no partial byte is kept.
- `rxd` passes through a 2-flop synchronizer before use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronized `rxd`=0.
  - START: after `CLKS_PER_BIT`/2 cycles, re-sample. If still 0 go to DATA; otherwise treat as a glitch and return to IDLE.
  - DATA: sample 8 bits LSB first, one every `CLKS_PER_BIT` cycles, at bit centre.
  - STOP: sample at stop-bit centre.
    - Stop bit 1: byte valid; `led` <= byte on the next edge.
    - Stop bit 0: set `err[0]`, drop the byte, leave `led` unchanged. Wait for `rxd`=1 before returning to IDLE.
- Holding register: 1 byte plus a valid flag, feeding TX (or SPI when `SPI_EN` is defined).
  - A valid byte arriving while the holding register is full is dropped and sets `err[1]`.
  - `err` bits clear only on reset.
- TX FSM states: IDLE, START, DATA, STOP.
  - Starts when the holding register is valid and TX is IDLE; the holding register is cleared in the same cycle.
  - Frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - A back-to-back byte may start in the cycle after the stop bit ends.
- Echo latency without `SPI_EN`: `txd` falls exactly 2 cycles after the stop-bit sample edge.
- Simultaneous events:
  - RX valid and TX load in the same cycle: TX takes the old byte and the holding register takes the new one; no overrun.
  - Continuous back-to-back RX at equal baud never overruns.

Optional Feature:
- Macro: `SPI_EN`.
- Defined: the holding register feeds an SPI master, mode 0, MSB first.
  - `spi_cs` falls, then after `SPI_DIV` cycles the first SCLK rise occurs.
  - `spi_mosi` changes only while `spi_sclk`=0; `spi_miso` is sampled on each SCLK rising edge.
  - 8 SCLK pulses per byte, each high and low phase `SPI_DIV` cycles.
  - After the last fall, `spi_cs` rises `SPI_DIV` cycles later.
  - The received MISO byte goes to a second 1-byte register feeding TX. Overrun rules apply to the SPI input.
  - `spi_cs` stays high at least `SPI_DIV` cycles between bytes.
- Undefined: SPI ports and logic are absent; the holding register feeds TX directly.

Test Plan (`CLKS_PER_BIT`=16, `SPI_DIV`=2):
1. Hold `rst_top`=0 for 3 cycles with `rxd`=1 → `txd`=1, `led`=0x00, `err`=0, `spi_cs`=1, `spi_sclk`=0.
2. Send 0x55 frame on `rxd` → `led`=0x55. `txd` falls 2 cycles after the stop sample, then sends bits 1,0,1,0,1,0,1,0 followed by stop 1, 16 cycles per bit. `err`=0.
3. Send 0xA5 then 0x3C back-to-back → echoed in order A5, 3C with no gap beyond the stop bit; `led`=0x3C; `err`=0.
4. Send 0xFF with the stop bit held 0 → no `txd` activity, `err`=2'b01, `led` unchanged. A following 0x12 is echoed normally.
5. Pulse `rxd` low for 4 cycles, then high → no byte, `led` unchanged, `txd` stays 1.
6. With `SPI_EN` and `spi_miso` = `spi_mosi` while `spi_cs`=0: send 0xC3 → `spi_cs` low for 8 SCLK pulses, `spi_mosi` = 1,1,0,0,0,0,1,1, then `txd` echoes 0xC3. With `spi_miso` tied to 0, the echo is 0x00.

Source files
------------

// File: rtl/uart_echo_chip_top.sv
// uart_echo_chip_top: echoes each correctly framed UART byte on rxd back out on txd
// Define SPI_EN to send each byte through an SPI master round trip and echo the byte read back.
module uart_echo_chip_top #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int SPI_DIV = 4
) (
  input  logic       clk_p,
  input  logic       clk_n,
  input  logic       rst_top,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] led,
  output logic [1:0] err
`ifdef SPI_EN
  ,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
`endif
);
  localparam logic [15:0] BIT_M = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M = 16'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  rx_t rs;
  tx_t ts;
  logic [1:0] sync;
  logic [15:0] rc, tc;
  logic [2:0] ri, ti;
  logic [7:0] rsh, tsh, hd, sd;
  logic rv, brk, hv, fe, ovr, take_h, tx_rdy, tx_go, sv, unused;
  assign unused = clk_n & (SPI_DIV > 0);
  assign fe = rs == R_STOP && !brk && rc == BIT_M && !sync[1];
  assign tx_rdy = ts == T_IDLE || (ts == T_STOP && tc == BIT_M);
  assign tx_go = tx_rdy && sv;
  always_ff @(posedge clk_p)
    if (!rst_top) begin
      sync <= 2'b11;
      rs <= R_IDLE;
      rc <= '0;
      ri <= '0;
      rsh <= '0;
      rv <= 1'b0;
      brk <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      rv <= 1'b0;
      case (rs)
        R_IDLE: begin
          rc <= '0;
          brk <= 1'b0;
          if (!sync[1]) rs <= R_START;
        end
        R_START:
          if (rc == HALF_M) begin
            rc <= '0;
            ri <= '0;
            rs <= sync[1] ? R_IDLE : R_DATA;
          end else rc <= rc + 16'd1;
        R_DATA:
          if (rc == BIT_M) begin
            rc <= '0;
            rsh <= {sync[1], rsh[7:1]};
            ri <= ri + 3'd1;
            if (ri == 3'd7) rs <= R_STOP;
          end else rc <= rc + 16'd1;
        R_STOP:
          // after a framing error, hold here until the line returns to idle
          if (brk) begin
            if (sync[1]) rs <= R_IDLE;
          end else if (rc == BIT_M) begin
            if (sync[1]) begin
              rv <= 1'b1;
              rs <= R_IDLE;
            end else brk <= 1'b1;
          end else rc <= rc + 16'd1;
      endcase
    end
  always_ff @(posedge clk_p)
    if (!rst_top) begin
      led <= '0;
      err <= '0;
      hv <= 1'b0;
      hd <= '0;
    end else begin
      if (rv) led <= rsh;
      err <= err | {ovr, fe};
      hd <= (rv && !(hv && !take_h)) ? rsh : hd;
      hv <= (hv && !take_h) || rv;
    end
`ifdef SPI_EN
  localparam logic [15:0] DIV_M = 16'(SPI_DIV - 1);
  typedef enum logic [2:0] {P_IDLE, P_LEAD, P_HIGH, P_LOW, P_TRAIL, P_GAP} spi_t;
  spi_t sp;
  logic [15:0] pc;
  logic [2:0] pi;
  logic [7:0] psh, prx, h2d;
  logic spv, h2v;
  assign take_h = sp == P_IDLE && hv;
  assign sv = h2v;
  assign sd = h2d;
  assign ovr = (rv && hv && !take_h) || (spv && h2v && !tx_go);
  always_ff @(posedge clk_p)
    if (!rst_top) begin
      sp <= P_IDLE;
      spi_cs <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      pc <= '0;
      pi <= '0;
      psh <= '0;
      prx <= '0;
      spv <= 1'b0;
    end else begin
      spv <= 1'b0;
      case (sp)
        P_IDLE:
          if (hv) begin
            spi_cs <= 1'b0;
            spi_mosi <= hd[7];
            psh <= {hd[6:0], 1'b0};
            pc <= '0;
            pi <= '0;
            sp <= P_LEAD;
          end
        P_LEAD, P_LOW:
          if (pc == DIV_M) begin
            pc <= '0;
            spi_sclk <= 1'b1;
            prx <= {prx[6:0], spi_miso};
            sp <= P_HIGH;
          end else pc <= pc + 16'd1;
        P_HIGH:
          // mosi advances together with the falling sclk edge
          if (pc == DIV_M) begin
            pc <= '0;
            spi_sclk <= 1'b0;
            pi <= pi + 3'd1;
            if (pi == 3'd7) sp <= P_TRAIL;
            else begin
              spi_mosi <= psh[7];
              psh <= psh << 1;
              sp <= P_LOW;
            end
          end else pc <= pc + 16'd1;
        P_TRAIL:
          if (pc == DIV_M) begin
            pc <= '0;
            spi_cs <= 1'b1;
            spv <= 1'b1;
            sp <= P_GAP;
          end else pc <= pc + 16'd1;
        P_GAP:
          if (pc == DIV_M) begin
            pc <= '0;
            sp <= P_IDLE;
          end else pc <= pc + 16'd1;
        default: sp <= P_IDLE;
      endcase
    end
  always_ff @(posedge clk_p)
    if (!rst_top) begin
      h2v <= 1'b0;
      h2d <= '0;
    end else begin
      h2d <= (spv && !(h2v && !tx_go)) ? prx : h2d;
      h2v <= (h2v && !tx_go) || spv;
    end
`else
  assign take_h = tx_go;
  assign sv = hv;
  assign sd = hd;
  assign ovr = rv && hv && !take_h;
`endif
  always_ff @(posedge clk_p)
    if (!rst_top) begin
      ts <= T_IDLE;
      txd <= 1'b1;
      tc <= '0;
      ti <= '0;
      tsh <= '0;
    end else if (tx_go) begin
      ts <= T_START;
      txd <= 1'b0;
      tc <= '0;
      tsh <= sd;
    end else
      case (ts)
        T_IDLE: txd <= 1'b1;
        T_START:
          if (tc == BIT_M) begin
            tc <= '0;
            txd <= tsh[0];
            tsh <= tsh >> 1;
            ti <= '0;
            ts <= T_DATA;
          end else tc <= tc + 16'd1;
        T_DATA:
          if (tc == BIT_M) begin
            tc <= '0;
            txd <= (ti == 3'd7) ? 1'b1 : tsh[0];
            tsh <= tsh >> 1;
            ti <= ti + 3'd1;
            if (ti == 3'd7) ts <= T_STOP;
          end else tc <= tc + 16'd1;
        T_STOP:
          if (tc == BIT_M) ts <= T_IDLE;
          else tc <= tc + 16'd1;
      endcase
endmodule

// File: tb/tb_uart_echo_chip_top.sv
// tb_uart_echo_chip_top: directed checks of reset, echo, back-to-back, framing error, glitch and SPI loopback
module tb_uart_echo_chip_top;
  localparam int CPB = 16;
  localparam int DIV = 2;
  localparam int LAT = `ifdef SPI_EN 193 `else 157 `endif;
  logic clk_p = 1'b0, clk_n, rst_top = 1'b0, rxd = 1'b1, txd;
  logic [7:0] led;
  logic [1:0] err;
  int checks = 0, errors = 0, cyc = 0, last_fall = 0;
  logic [7:0] mq[$];
  int mt[$];
  bit ms[$];
  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;
  always @(posedge clk_p) cyc <= cyc + 1;
`ifdef SPI_EN
  logic spi_cs, spi_sclk, spi_mosi, spi_miso, loop = 1'b1;
  logic [7:0] mbits = '0;
  int npulse = 0, ncs = 0;
  assign spi_miso = loop & ~spi_cs & spi_mosi;
  always @(posedge spi_sclk) begin
    mbits = {mbits[6:0], spi_mosi};
    npulse++;
  end
  always @(negedge spi_cs) ncs++;
`endif
  uart_echo_chip_top #(.CLKS_PER_BIT(CPB), .SPI_DIV(DIV)) dut (
    .clk_p(clk_p), .clk_n(clk_n), .rst_top(rst_top), .rxd(rxd), .txd(txd), .led(led), .err(err)
`ifdef SPI_EN
    , .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
`endif
  );
  // txd decoder: records byte, first-low cycle and framing of every echoed frame
  initial begin
    int t;
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk_p);
      if (rst_top === 1'b1 && txd === 1'b0) begin
        t = cyc;
        repeat (CPB / 2) @(negedge clk_p);
        ok = (txd === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk_p);
          b[k] = txd;
        end
        repeat (CPB) @(negedge clk_p);
        ok = ok && (txd === 1'b1);
        mq.push_back(b);
        mt.push_back(t);
        ms.push_back(ok);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk_p);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
    rxd = 1'b1;
  endtask
  task automatic echo_chk(input string tag, input logic [7:0] eb, input int et);
    int k;
    k = 0;
    while (mq.size() == 0 && k < 600) begin
      @(negedge clk_p);
      k++;
    end
    check({tag, "_seen"}, 32'(mq.size() > 0), 1);
    if (mq.size() > 0) begin
      last_fall = mt.pop_front();
      check({tag, "_byte"}, mq.pop_front(), eb);
      check({tag, "_frame"}, 32'(ms.pop_front()), 1);
      check({tag, "_lat"}, last_fall, et);
    end
  endtask
  initial begin
    int t1, t2, f1;
    idle(3);
    check("rst_txd", txd, 1);
    check("rst_led", led, 0);
    check("rst_err", err, 0);
`ifdef SPI_EN
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_sclk, 0);
`endif
    rst_top = 1'b1;
    idle(5);
    send(8'h55, 1'b1, t1);
    check("55_led", led, 8'h55);
    check("55_err", err, 0);
    echo_chk("55", 8'h55, t1 + LAT);
    idle(20);
    send(8'hA5, 1'b1, t1);
    send(8'h3C, 1'b1, t2);
    echo_chk("a5", 8'hA5, t1 + LAT);
    f1 = last_fall;
    echo_chk("3c", 8'h3C, t2 + LAT);
    check("b2b_gap", last_fall - f1, 10 * CPB);
    check("b2b_led", led, 8'h3C);
    check("b2b_err", err, 0);
    idle(20);
    send(8'hFF, 1'b0, t1);
    idle(200);
    check("fe_quiet", mq.size(), 0);
    check("fe_err", err, 2'b01);
    check("fe_led", led, 8'h3C);
    idle(20);
    send(8'h12, 1'b1, t1);
    echo_chk("12", 8'h12, t1 + LAT);
    check("12_led", led, 8'h12);
    check("12_err", err, 2'b01);
    idle(20);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(200);
    check("glitch_quiet", mq.size(), 0);
    check("glitch_led", led, 8'h12);
    check("glitch_txd", txd, 1);
`ifdef SPI_EN
    mbits = '0;
    npulse = 0;
    ncs = 0;
    send(8'hC3, 1'b1, t1);
    echo_chk("spi_c3", 8'hC3, t1 + LAT);
    check("spi_pulses", npulse, 8);
    check("spi_mosi", mbits, 8'hC3);
    check("spi_cs_falls", ncs, 1);
    check("spi_cs_idle", spi_cs, 1);
    loop = 1'b0;
    idle(20);
    send(8'hC3, 1'b1, t1);
    echo_chk("spi_zero", 8'h00, t1 + LAT);
`endif
    idle(20);
    rxd = 1'b0;
    idle(60);
    rst_top = 1'b0;
    rxd = 1'b1;
    idle(3);
    check("midrst_led", led, 0);
    check("midrst_err", err, 0);
    check("midrst_txd", txd, 1);
    rst_top = 1'b1;
    idle(250);
    check("midrst_quiet", mq.size(), 0);
    check("midrst_led_after", led, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
